cs5361_rx: RTL and testbench

//  Receiver stage directly downstream of the CS5361 ADC serial port.
//  - Oversamples lrck/sclk/sdata on mclk and deserializes one stereo frame into 24-bit left/right words.
//  - Presents each frame as a pair on a valid/ready interface to the capture/record logic.
//  - ADC runs as serial master: sclk = mclk/4, lrck = mclk/256, lrck high = left, sdata changes on sclk fall.

---
 rtl/cs5361_rx.sv | 196 +++++++++++++++++++
 tb/tb_cs5361_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs5361_rx.sv
// cs5361_rx: oversampling receiver for the CS5361 serial port, delivering stereo pairs on valid/ready.
// Define I2S_DELAY_EN for I2S (one-bit delayed) alignment; left-justified alignment otherwise.
module cs5361_rx #(
    parameter int DATA_W        = 24,
    parameter int BCLK_PER_HALF = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              lrck_in,
    input  logic              sdata_in,
    input  logic              ovfl_in_,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              clip
);
    localparam int CNT_W = $clog2(BCLK_PER_HALF + DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(BCLK_PER_HALF);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(BCLK_PER_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef I2S_DELAY_EN
    localparam logic [CNT_W-1:0] SHIFT_LIM = CNT_W'(DATA_W + 1);
    localparam logic             FIRST_EN  = 1'b0;
`else
    localparam logic [CNT_W-1:0] SHIFT_LIM = CNT_W'(DATA_W);
    localparam logic             FIRST_EN  = 1'b1;
`endif

    typedef enum logic [1:0] {
        WAIT_L  = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, lrck_sync_q, sdata_sync_q, ovfl_sync_q;
    logic                   sclk_s, lrck_s, sdata_s, ovfl_s;
    logic                   sclk_prev_q;
    logic                   sclk_rise, boundary, start_half;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lrck_last_q, lrck_last_d;
    logic                   primed_q, primed_d;
    logic [DATA_W-1:0]      left_hold_q, left_hold_d;
    logic [DATA_W-1:0]      pair_l_q, pair_l_d;
    logic [DATA_W-1:0]      pair_r_q, pair_r_d;
    logic                   new_pair_q, new_pair_d;
    logic [DATA_W-1:0]      left_data_q, left_data_d;
    logic [DATA_W-1:0]      right_data_q, right_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   clip_q, clip_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign ovfl_s    = ovfl_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    // The first sampled lrck after reset only seeds the history, so a half already in progress is never taken as a boundary.
    assign boundary  = primed_q && (lrck_s != lrck_last_q);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        lrck_last_d = lrck_last_q;
        primed_d    = primed_q;
        left_hold_d = left_hold_q;
        pair_l_d    = pair_l_q;
        pair_r_d    = pair_r_q;
        new_pair_d  = 1'b0;
        frame_err_d = frame_err_q;
        clip_d      = clip_q;
        start_half  = 1'b0;
        if (sclk_rise) begin
            lrck_last_d = lrck_s;
            primed_d    = 1'b1;
            if (state_q != WAIT_L && !ovfl_s) clip_d = 1'b1;
            if (boundary) begin
                case (state_q)
                    WAIT_L: begin
                        if (lrck_s) begin
                            state_d    = SHIFT_L;
                            start_half = 1'b1;
                        end
                    end
                    SHIFT_L: begin
                        if (!lrck_s) begin
                            left_hold_d = sh_q;
                            state_d     = SHIFT_R;
                            start_half  = 1'b1;
                            if (cnt_q != CNT_EXP) frame_err_d = 1'b1;
                        end
                    end
                    SHIFT_R: begin
                        if (lrck_s) begin
                            pair_l_d   = left_hold_q;
                            pair_r_d   = sh_q;
                            new_pair_d = 1'b1;
                            state_d    = SHIFT_L;
                            start_half = 1'b1;
                            if (cnt_q != CNT_EXP) frame_err_d = 1'b1;
                        end
                    end
                    default: state_d = WAIT_L;
                endcase
            end else if (state_q != WAIT_L) begin
                if (cnt_q < SHIFT_LIM) sh_d = {sh_q[DATA_W-2:0], sdata_s};
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
            end
        end
        // The boundary edge is counted as the first edge of the new half; it carries the MSB only in LJ mode.
        if (start_half) begin
            cnt_d = CNT_ONE;
            sh_d  = {{(DATA_W-1){1'b0}}, sdata_s & FIRST_EN};
        end
    end

    always_comb begin
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        if (new_pair_q) begin
            if (!out_valid_q || out_ready) begin
                left_data_d  = pair_l_q;
                right_data_d = pair_r_q;
                out_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdata_sync_q <= '0;
            ovfl_sync_q  <= '1;
            sclk_prev_q  <= 1'b0;
            state_q      <= WAIT_L;
            sh_q         <= '0;
            cnt_q        <= '0;
            lrck_last_q  <= 1'b0;
            primed_q     <= 1'b0;
            left_hold_q  <= '0;
            pair_l_q     <= '0;
            pair_r_q     <= '0;
            new_pair_q   <= 1'b0;
            left_data_q  <= '0;
            right_data_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            clip_q       <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_in};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
            ovfl_sync_q  <= {ovfl_sync_q[SYNC_STAGES-2:0], ovfl_in_};
            sclk_prev_q  <= sclk_s;
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            lrck_last_q  <= lrck_last_d;
            primed_q     <= primed_d;
            left_hold_q  <= left_hold_d;
            pair_l_q     <= pair_l_d;
            pair_r_q     <= pair_r_d;
            new_pair_q   <= new_pair_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            clip_q       <= clip_d;
        end
    end

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign clip       = clip_q;
endmodule

// File: tb/tb_cs5361_rx.sv
// Bench for cs5361_rx: serializes stereo frames like the ADC master port and scores the delivered pairs.
// With I2S_DELAY_EN defined the serializer inserts the one-bit I2S delay.
`timescale 1ns/1ps
module tb_cs5361_rx;
    localparam int DATA_W = 24;
    localparam int BCLK   = 32;
    localparam int SYNC   = 2;
`ifdef I2S_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic        mclk = 1'b0;
    logic        rst, sclk_in, lrck_in, sdata_in, ovfl_in_, out_ready;
    logic [23:0] left_data, right_data;
    logic        out_valid, overrun, frame_err, clip;

    logic [47:0] exp_q[$];
    logic [47:0] mon_exp;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_xfer   = 0;
    event        left_rise_ev;

    cs5361_rx #(.DATA_W(DATA_W), .BCLK_PER_HALF(BCLK), .SYNC_STAGES(SYNC)) dut (
        .mclk(mclk), .rst(rst), .sclk_in(sclk_in), .lrck_in(lrck_in),
        .sdata_in(sdata_in), .ovfl_in_(ovfl_in_), .left_data(left_data),
        .right_data(right_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .frame_err(frame_err), .clip(clip)
    );

    always #5 mclk = ~mclk;

    // Scoreboard: every accepted pair must match the oldest expected pair.
    always @(negedge mclk) begin
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_xfer++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pair_unexpected: got %h/%h, expected no pair", left_data, right_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({left_data, right_data} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL pair_data: got %h/%h, expected %h/%h", left_data, right_data,
                             mon_exp[47:24], mon_exp[23:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge mclk);
        rst = 1'b1; sclk_in = 1'b0; lrck_in = 1'b0; sdata_in = 1'b0; ovfl_in_ = 1'b1;
        repeat (4) @(negedge mclk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // One sclk period = 4 mclk; lrck/sdata/ovfl change with the sclk fall.
    task automatic sclk_cycle(input logic lr, input logic d, input logic ov, input logic mark);
        @(negedge mclk);
        sclk_in = 1'b0; lrck_in = lr; sdata_in = d; ovfl_in_ = ov;
        @(negedge mclk);
        @(negedge mclk);
        sclk_in = 1'b1;
        if (mark) -> left_rise_ev;
        @(negedge mclk);
    endtask

    task automatic send_half(input logic lr, input logic [23:0] d, input int first, input int last,
                             input int ov_from, input int ov_to);
        for (int i = first; i < last; i++) begin
            int   k;
            logic b;
            k = i - DLY;
            b = (k >= 0 && k < DATA_W) ? d[DATA_W-1-k] : 1'b0;
            sclk_cycle(lr, b, !(i >= ov_from && i < ov_to), lr && (i == 0));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_half(1'b1, l, 0, BCLK, -1, -1);
        send_half(1'b0, r, 0, BCLK, -1, -1);
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk_in = 1'b0; lrck_in = 1'b0; sdata_in = 1'b0; ovfl_in_ = 1'b1; out_ready = 1'b0;
        repeat (4) @(negedge mclk);
        n_checks++; if (left_data !== 24'h0) begin n_errors++; $display("FAIL reset_left: got %h expected 000000", left_data); end
        n_checks++; if (right_data !== 24'h0) begin n_errors++; $display("FAIL reset_right: got %h expected 000000", right_data); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if ({overrun, frame_err, clip} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 000", {overrun, frame_err, clip});
        end
        rst = 1'b0;
    endtask

    task automatic test_lj_pairs();
        logic [23:0] l_tab[5];
        logic [23:0] r_tab[5];
        int          n0;
        l_tab = '{24'h000000, 24'h000001, 24'h000002, 24'($urandom()), 24'($urandom())};
        r_tab = '{24'h000000, 24'hFFFFFF, 24'hFFFFFE, 24'($urandom()), 24'($urandom())};
        do_reset();
        out_ready = 1'b1;
        n0 = n_xfer;
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        for (int f = 0; f < 5; f++) begin
            exp_q.push_back({l_tab[f], r_tab[f]});
            send_frame(l_tab[f], r_tab[f]);
        end
        send_half(1'b1, 24'h0, 0, BCLK, -1, -1);
        repeat (4) @(negedge mclk);
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL lj_missing: got %0d pending expected 0", exp_q.size()); end
        n_checks++; if (n_xfer - n0 != 5) begin n_errors++; $display("FAIL lj_count: got %0d pairs expected 5", n_xfer - n0); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lj_valid_drop: got %b expected 0", out_valid); end
        n_checks++; if ({overrun, frame_err, clip} !== 3'b000) begin
            n_errors++; $display("FAIL lj_flags: got %b expected 000", {overrun, frame_err, clip});
        end
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready = 1'b0;
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        exp_q.push_back({24'h800001, 24'h7FFFFE});
        send_frame(24'h800001, 24'h7FFFFE);
        send_frame(24'h123456, 24'h654321);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_valid_held: got %b expected 1", out_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_early: got %b expected 0", overrun); end
        send_frame(24'h0ABCDE, 24'hFEDCBA);
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        n_checks++; if ({left_data, right_data} !== {24'h800001, 24'h7FFFFE}) begin
            n_errors++; $display("FAIL ovr_hold: got %h/%h expected 800001/7ffffe", left_data, right_data);
        end
        send_half(1'b1, 24'h0, 0, BCLK, -1, -1);
        n_checks++; if ({left_data, right_data} !== {24'h800001, 24'h7FFFFE}) begin
            n_errors++; $display("FAIL ovr_hold_late: got %h/%h expected 800001/7ffffe", left_data, right_data);
        end
        @(negedge mclk);
        out_ready = 1'b1;
        repeat (3) @(negedge mclk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_dropped: got %b expected 0", out_valid); end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL ovr_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        exp_q.push_back({24'h111111, 24'h222222});
        exp_q.push_back({24'h333333, 24'h444444});
        send_frame(24'h111111, 24'h222222);
        send_frame(24'h333333, 24'h444444);
        fork
            send_frame(24'h555555, 24'h666666);
            begin
                @(left_rise_ev);
                repeat (SYNC + 1) @(negedge mclk);
                out_ready = 1'b1;
                @(negedge mclk);
                out_ready = 1'b0;
            end
        join
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        n_checks++; if ({left_data, right_data} !== {24'h333333, 24'h444444}) begin
            n_errors++; $display("FAIL b2b_data: got %h/%h expected 333333/444444", left_data, right_data);
        end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        n_checks++; if (exp_q.size() != 1) begin n_errors++; $display("FAIL b2b_first_taken: got %0d pending expected 1", exp_q.size()); end
        out_ready = 1'b1;
        repeat (3) @(negedge mclk);
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL b2b_second_taken: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_frame_err();
        int n0;
        do_reset();
        out_ready = 1'b1;
        n0 = n_xfer;
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        exp_q.push_back({24'hC0FFEE, 24'h0DDBA1});
        send_frame(24'hC0FFEE, 24'h0DDBA1);
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL ferr_clean: got %b expected 0", frame_err); end
        exp_q.push_back({24'hABCDEF, 24'h135790});
        send_half(1'b1, 24'hABCDEF, 0, BCLK - 1, -1, -1);
        send_half(1'b0, 24'h135790, 0, BCLK, -1, -1);
        send_half(1'b1, 24'h0, 0, BCLK, -1, -1);
        n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        n_checks++; if (n_xfer - n0 != 2 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL ferr_delivered: got %0d pairs expected 2", n_xfer - n0);
        end
    endtask

    task automatic test_clip_reset();
        do_reset();
        out_ready = 1'b0;
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        send_half(1'b1, 24'h2468AC, 0, BCLK, 8, 16);
        send_half(1'b0, 24'h13579B, 0, BCLK, -1, -1);
        send_half(1'b1, 24'h0, 0, BCLK / 2, -1, -1);
        n_checks++; if (clip !== 1'b1) begin n_errors++; $display("FAIL clip_set: got %b expected 1", clip); end
        n_checks++; if (out_valid !== 1'b1 || {left_data, right_data} !== {24'h2468AC, 24'h13579B}) begin
            n_errors++; $display("FAIL clip_pair: got %b %h/%h expected 1 2468ac/13579b", out_valid, left_data, right_data);
        end
        @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        n_checks++; if ({overrun, frame_err, clip} !== 3'b000) begin
            n_errors++; $display("FAIL rst_mid_flags: got %b expected 000", {overrun, frame_err, clip});
        end
        out_ready = 1'b1;
        send_half(1'b1, 24'h0, BCLK / 2, BCLK, -1, -1);
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        exp_q.push_back({24'hFEDCBA, 24'h012345});
        send_frame(24'hFEDCBA, 24'h012345);
        send_half(1'b1, 24'h0, 0, BCLK, -1, -1);
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rst_next_frame: got %0d pending expected 0", exp_q.size()); end
        n_checks++; if ({frame_err, clip} !== 2'b00) begin
            n_errors++; $display("FAIL rst_next_flags: got %b expected 00", {frame_err, clip});
        end
    endtask

    task automatic test_i2s_values();
        int n0;
        do_reset();
        out_ready = 1'b1;
        n0 = n_xfer;
        send_half(1'b0, 24'h0, 0, BCLK, -1, -1);
        exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        send_frame(24'hA5A5A5, 24'h5A5A5A);
        send_half(1'b1, 24'h0, 0, BCLK, -1, -1);
        n_checks++; if (n_xfer - n0 != 1 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL align_pair: got %0d pairs expected 1", n_xfer - n0);
        end
    endtask

    initial begin
        test_reset();
        test_lj_pairs();
        test_overrun();
        test_back_to_back();
        test_frame_err();
        test_clip_reset();
        test_i2s_values();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
